// File: rtl/fml_responder.sv
// FastMemoryLink memory-side responder: arbitrates one read and one write port,
// returns 4-beat read bursts at a fixed latency and commits byte-enabled write bursts.
module fml_responder #(
    parameter int unsigned DEPTH_LOG2   = 6,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [25:0] fmlr_adr,
    input  logic        fmlr_stb,
    output logic        fmlr_ack,
    output logic [63:0] fmlr_di,
    input  logic [25:0] fmlw_adr,
    input  logic        fmlw_stb,
    output logic        fmlw_ack,
    input  logic [7:0]  fmlw_sel,
    input  logic [63:0] fmlw_do,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_e;

    localparam int unsigned WORDS     = 4 << DEPTH_LOG2;
    localparam state_e      RD_FIRST  = (READ_LATENCY == 1) ? RD_BURST : RD_WAIT;
    localparam logic [2:0]  WAIT_LAST = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : '0;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] row_q, row_d;
    logic                  last_wr_q, last_wr_d;
    logic                  rack_q, rack_d;
    logic                  wack_q, wack_d;
    logic                  busy_q, busy_d;
    logic [63:0]           di_q, di_d;
    logic                  gnt_r, gnt_w;
    logic [2:0]            wbeat;
    logic                  wr_en;
    logic [63:0]           mem [WORDS];

    // In both burst states count 0 is the ack cycle (write) or the first
    // data-register load (read); count 4 keeps the FSM busy for the last beat.
    assign wbeat = cnt_q - 3'd1;
    assign wr_en = (state_q == WR_BURST) && (cnt_q != 3'd0);

    always_comb begin
        gnt_r = fmlr_stb && (!fmlw_stb || last_wr_q);
        gnt_w = fmlw_stb && (!fmlr_stb || !last_wr_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            last_wr_q <= 1'b1;
            rack_q    <= 1'b0;
            wack_q    <= 1'b0;
            busy_q    <= 1'b0;
            di_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            last_wr_q <= last_wr_d;
            rack_q    <= rack_d;
            wack_q    <= wack_d;
            busy_q    <= busy_d;
            di_q      <= di_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt_r) begin
                    row_d     = fmlr_adr[DEPTH_LOG2+4:5];
                    last_wr_d = 1'b0;
                    state_d   = RD_FIRST;
                end else if (gnt_w) begin
                    row_d     = fmlw_adr[DEPTH_LOG2+4:5];
                    last_wr_d = 1'b1;
                    state_d   = WR_BURST;
                end
            end
            RD_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = RD_BURST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                if (cnt_q == 3'd4) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
        endcase
    end

    always_comb begin
        rack_d = (state_q == IDLE) && gnt_r;
        wack_d = (state_q == IDLE) && gnt_w;
        busy_d = (state_d != IDLE);
        di_d   = '0;
        if (state_q == RD_BURST && cnt_q != 3'd4) begin
            di_d = mem[{row_q, cnt_q[1:0]}];
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (fmlw_sel[i]) begin
                    mem[{row_q, wbeat[1:0]}][8*i +: 8] <= fmlw_do[8*i +: 8];
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{fmlr_adr[25:DEPTH_LOG2+5], fmlr_adr[4:0],
                           fmlw_adr[25:DEPTH_LOG2+5], fmlw_adr[4:0], wbeat[2]};

    assign fmlr_ack = rack_q;
    assign fmlw_ack = wack_q;
    assign fmlr_di  = di_q;
    assign busy     = busy_q;

endmodule
